// File: rtl/uart_sender_if.sv
// uart_sender_if
//   Byte-level request/status bundle between a character producer and the
//   UART transmitter.
//
//   Handshake: the master raises start for one cycle with data valid. The
//   slave accepts it only when busy is low. busy goes high on the following
//   cycle and stays high until the frame's stop bit ends. A start seen while
//   busy is high is dropped, and nothing is queued. A master that holds start
//   high gets a new frame on the first idle cycle.
//
//   Signals
//     start      master->slave  one-cycle transmit request
//     data[7:0]  master->slave  byte to send, sampled when start is accepted
//     busy       slave->master  frame in flight
//     tx         slave->master  serial line (idle high)
//     state_dbg  slave->master  transmitter FSM state, for observation only
interface uart_sender_if;
    logic       start;
    logic [7:0] data;
    logic       busy;
    logic       tx;
    logic [1:0] state_dbg;

    modport master (output start, data, input busy, tx, state_dbg);
    modport slave  (input start, data, output busy, tx, state_dbg);
endinterface

// File: rtl/uart_sender.sv
// uart_sender
//   8N1 UART transmitter that sends LSB first on an idle-high line. It
//   accepts one byte per start pulse while idle. The frame is 10 bit periods
//   long: one start bit, eight data bits and one stop bit. Every output is
//   registered, so no combinational path runs from start to busy or tx.
//
//   Ports
//     clock    system clock, rising edge
//     reset_n  synchronous active-low reset; it aborts a frame in flight
//     bus      uart_sender_if.slave (start, data, busy, tx, state_dbg)
//
//   Parameter
//     CLKS_PER_BIT  clock cycles per bit period, must be >= 2
module uart_sender #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic           clock,
    input  logic           reset_n,
    uart_sender_if.slave   bus
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q,  baud_d;
    logic [2:0]        bit_q,   bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q,    tx_d;
    logic              busy_q,  busy_d;
    logic              baud_wrap;

    // The last cycle of the current bit period.
    assign baud_wrap = (baud_q == BAUD_LAST);

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start)                   state_d = START;
            START:   if (baud_wrap)                   state_d = DATA;
            DATA:    if (baud_wrap && bit_q == 3'd7)  state_d = STOP;
            STOP:    if (baud_wrap)                   state_d = IDLE;
            default:                                  state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and the datapath. tx and busy are
    // computed one cycle ahead and registered, so each new line level appears
    // on the same edge as the state change that produces it.
    always_comb begin
        baud_d  = baud_wrap ? '0 : baud_q + BAUD_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (bus.start) begin
                    shift_d = bus.data;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (baud_wrap) begin
                    tx_d  = shift_q[0];
                    bit_d = '0;
                end
            end
            DATA: begin
                // shift_q[0] is the bit on the line now, and shift_q[1] is
                // the next bit to send.
                if (baud_wrap) begin
                    if (bit_q == 3'd7) begin
                        tx_d = 1'b1;
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (baud_wrap) begin
                    busy_d = 1'b0;
                end
            end
            default: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

    assign bus.tx        = tx_q;
    assign bus.busy      = busy_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_uart_sender.sv
// tb_uart_sender
//   Directed bench for uart_sender with CLKS_PER_BIT=4. The bench drives
//   inputs 1 time unit after the rising edge. It samples frames in the middle
//   of each bit period. A line monitor decodes the back-to-back sequence
//   against a queue of expected bytes.
module tb_uart_sender;

    localparam int CPB = 4;

    logic clock;
    logic reset_n;
    int   n_vec;
    int   n_miss;
    int   n_decoded;
    logic mon_en;
    logic [7:0] exp_q[$];

    uart_sender_if bus ();

    uart_sender #(.CLKS_PER_BIT(CPB)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Clock and reset.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Sends one byte and checks the whole frame. Call it while idle, at
    // posedge+1. exp_bits[k] is the expected line level in bit period k:
    // start, D0..D7, stop. If spoil_at >= 0, a second start with spoil_data
    // is pulsed at that frame cycle and must have no effect.
    task automatic run_frame(input string name, input logic [7:0] d,
                             input logic [9:0] exp_bits,
                             input int spoil_at, input logic [7:0] spoil_data);
        int busy_cnt;
        busy_cnt = 0;
        bus.start = 1'b1;
        bus.data  = d;
        for (int c = 0; c < 42; c++) begin
            tick();
            bus.start = 1'b0;
            // The byte is latched at acceptance, so later data changes must
            // not matter.
            if (c == 0) bus.data = ~d;
            if (c == spoil_at) begin
                bus.start = 1'b1;
                bus.data  = spoil_data;
            end
            if (bus.busy) busy_cnt++;
            if (c == 0) begin
                check({name, "_first_busy"}, 32'(bus.busy), 32'd1);
                check({name, "_first_tx"},   32'(bus.tx),   32'd0);
            end
            if (c < 40 && (c % CPB) == 2)
                check($sformatf("%s_bit%0d", name, c / CPB), 32'(bus.tx), 32'(exp_bits[c / CPB]));
            if (c >= 40) begin
                check($sformatf("%s_after_busy%0d", name, c), 32'(bus.busy), 32'd0);
                check($sformatf("%s_after_tx%0d", name, c),   32'(bus.tx),   32'd1);
            end
        end
        check({name, "_busy_len"}, 32'(busy_cnt), 32'd40);
    endtask

    // Line monitor: decodes frames from tx while mon_en is set.
    initial begin
        logic       prev_tx;
        logic [7:0] b;
        logic [8:0] exp_b;
        prev_tx = 1'b1;
        forever begin
            @(negedge clock);
            if (mon_en && prev_tx && !bus.tx) begin
                repeat (2) @(negedge clock);
                check("mon_start_bit", 32'(bus.tx), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clock);
                    b[i] = bus.tx;
                end
                repeat (CPB) @(negedge clock);
                check("mon_stop_bit", 32'(bus.tx), 32'd1);
                exp_b = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
                check("mon_byte", {24'd0, b}, {23'd0, exp_b});
                n_decoded++;
            end
            prev_tx = bus.tx;
        end
    end

    initial begin
        int gap;
        int blen;
        int guard;
        n_vec     = 0;
        n_miss    = 0;
        n_decoded = 0;
        mon_en    = 1'b0;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.data  = 8'h00;

        // Reset held for 3 cycles.
        repeat (3) tick();
        check("reset_tx",    32'(bus.tx),        32'd1);
        check("reset_busy",  32'(bus.busy),      32'd0);
        check("reset_state", 32'(bus.state_dbg), 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("quiet_busy%0d", i), 32'(bus.busy), 32'd0);
            check($sformatf("quiet_tx%0d", i),   32'(bus.tx),   32'd1);
        end

        // B2: 0,0,1,0,0,1,1,0,1,1 over the ten bit periods.
        run_frame("b2", 8'hB2, 10'b1101100100, -1, 8'h00);
        // 20: data bits 0,0,0,0,0,1,0,0.
        run_frame("sp", 8'h20, 10'b1001000000, -1, 8'h00);
        // 55, with a start for FF at frame cycle 10 that must be ignored.
        run_frame("55", 8'h55, 10'b1010101010, 10, 8'hFF);

        // Reset during frame cycle 15.
        bus.start = 1'b1;
        bus.data  = 8'h55;
        for (int c = 0; c < 16; c++) begin
            tick();
            bus.start = 1'b0;
        end
        check("pre_reset_busy", 32'(bus.busy), 32'd1);
        reset_n = 1'b0;
        tick();
        check("midreset_tx",   32'(bus.tx),   32'd1);
        check("midreset_busy", 32'(bus.busy), 32'd0);
        reset_n = 1'b1;
        tick();
        check("postreset_idle_busy", 32'(bus.busy), 32'd0);
        run_frame("post", 8'hB2, 10'b1101100100, -1, 8'h00);

        // start held high with bytes alternating B2/20. Frames must run back
        // to back, with one idle cycle between them.
        mon_en = 1'b1;
        tick();
        bus.start = 1'b1;
        for (int f = 0; f < 4; f++) begin
            bus.data = (f % 2 == 0) ? 8'hB2 : 8'h20;
            exp_q.push_back(bus.data);
            gap   = 0;
            guard = 0;
            while (!bus.busy && guard < 100) begin
                if (f > 0) check($sformatf("gap_tx_f%0d", f), 32'(bus.tx), 32'd1);
                gap++;
                guard++;
                tick();
            end
            if (guard >= 100) check("timeout_busy_rise", 32'd0, 32'd1);
            if (f > 0) check($sformatf("idle_gap_f%0d", f), 32'(gap), 32'd1);
            blen  = 0;
            guard = 0;
            while (bus.busy && guard < 100) begin
                blen++;
                guard++;
                tick();
            end
            if (guard >= 100) check("timeout_busy_fall", 32'd0, 32'd1);
            check($sformatf("frame_len_f%0d", f), 32'(blen), 32'd40);
        end
        bus.start = 1'b0;
        repeat (8) tick();
        check("cont_decoded", 32'(n_decoded), 32'd4);
        check("cont_queue_left", 32'(exp_q.size()), 32'd0);
        check("final_idle_busy", 32'(bus.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
